// File: rtl/ppla_spi_arbiter_pkg.sv
// Shared state type and helpers for the SPI bus arbiter.
package ppla_spi_arbiter_pkg;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StResp} arb_state_e;

    localparam int unsigned MaxReq = 8;

    // Cycles from the accept pulse to the response pulse.
    function automatic int unsigned resp_latency(input int unsigned cs_setup,
                                                 input int unsigned clk_div,
                                                 input int unsigned data_w,
                                                 input int unsigned cs_hold);
        return cs_setup + 2 * clk_div * data_w + cs_hold + 1;
    endfunction

    // First set bit of valid at or above ptr, wrapping within num_req entries.
    function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int unsigned       num_req);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            idx = (32'(ptr) + i) % num_req;
            if (i < num_req && !found && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ppla_spi_shift_engine.sv
// Mode-0 SPI shift engine: divides the system clock into SCK and shifts DATA_W bits MSB
// first, MOSI advancing on SCK fall and MISO sampled on SCK rise.
module ppla_spi_shift_engine #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] wdata,
    input  logic              en,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DivW = $clog2(2 * CLK_DIV);
    localparam int unsigned BitW = $clog2(DATA_W);

    logic [DivW-1:0]   div_q;
    logic [BitW-1:0]   bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              rise;
    logic              last_div;
    logic              last_bit;

    assign rise     = (div_q == DivW'(CLK_DIV - 1));
    assign last_div = (div_q == DivW'(2 * CLK_DIV - 1));
    assign last_bit = (bit_q == BitW'(DATA_W - 1));

    assign sck   = en & (div_q >= DivW'(CLK_DIV));
    assign mosi  = tx_q[DATA_W-1];
    assign done  = en & last_div & last_bit;
    assign rdata = rx_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            bit_q <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
        end else if (start) begin
            div_q <= '0;
            bit_q <= '0;
            tx_q  <= wdata;
            rx_q  <= '0;
        end else if (en) begin
            if (rise) begin
                rx_q <= {rx_q[DATA_W-2:0], miso};
            end
            if (last_div) begin
                div_q <= '0;
                // The final bit stays on MOSI until chip select is released.
                if (!last_bit) begin
                    bit_q <= bit_q + 1'b1;
                    tx_q  <= {tx_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppla_spi_arbiter.sv
// Round-robin arbiter sharing one mode-0 SPI bus between NUM_REQ requesters.
// Define PPLA_SPI_ARBITER_PRIO0_EN to give requester 0 strict priority.
module ppla_spi_arbiter
    import ppla_spi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       spi_sck,
    output logic                       spi_mosi,
    input  logic                       spi_miso,
    output logic [NUM_REQ-1:0]         spi_cs_n
);

    localparam int unsigned GntW = $clog2(NUM_REQ);
    localparam int unsigned CntW = 16;

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [GntW-1:0]   grant_q, grant_d;
    logic [GntW-1:0]   ptr_q, ptr_d;
    logic [GntW-1:0]   pick;
    logic              ptr_upd;
    logic              accept;
    logic [MaxReq-1:0] valid8;

    logic              eng_sck;
    logic              eng_mosi;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rdata;

    always_comb begin
        valid8  = MaxReq'(req_valid);
        ptr_upd = 1'b1;
`ifdef PPLA_SPI_ARBITER_PRIO0_EN
        if (req_valid[0]) begin
            pick    = '0;
            ptr_upd = 1'b0;
        end else begin
            pick = GntW'(rr_pick(valid8 & ~MaxReq'(1), 3'(ptr_q), NUM_REQ));
        end
`else
        pick = GntW'(rr_pick(valid8, 3'(ptr_q), NUM_REQ));
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!reset && |req_valid) begin
                    accept  = 1'b1;
                    grant_d = pick;
                    if (ptr_upd) begin
                        ptr_d = GntW'((32'(pick) + 1) % NUM_REQ);
                    end
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (eng_done) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    ppla_spi_shift_engine #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shift_engine (
        .clock (clock),
        .reset (reset),
        .start (accept),
        .wdata (req_wdata[pick*DATA_W +: DATA_W]),
        .en    (state_q == StShift),
        .miso  (spi_miso),
        .sck   (eng_sck),
        .mosi  (eng_mosi),
        .done  (eng_done),
        .rdata (eng_rdata)
    );

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        spi_cs_n   = '1;
        spi_mosi   = 1'b0;
        if (accept) begin
            req_ready[pick] = 1'b1;
        end
        if (state_q inside {StSetup, StShift, StHold}) begin
            spi_cs_n[grant_q] = 1'b0;
            spi_mosi          = eng_mosi;
        end
        if (state_q == StResp) begin
            resp_valid[grant_q] = 1'b1;
            resp_rdata          = eng_rdata;
        end
    end

    assign busy     = (state_q != StIdle);
    assign spi_sck  = eng_sck;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_ppla_spi_arbiter.sv
// Self-checking bench for ppla_spi_arbiter: cycle model of the bus timing plus directed
// scenarios. Honours PPLA_SPI_ARBITER_PRIO0_EN for the priority variant.
module tb_ppla_spi_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int CD  = 4;
    localparam int S   = 2;
    localparam int H   = 2;
    localparam int SH  = 2 * CD * DW;
    localparam int LAT = S + SH + H + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready, resp_valid, spi_cs_n;
    logic [DW-1:0]   resp_rdata;
    logic [1:0]      grant_id;
    logic            busy, spi_sck, spi_mosi, spi_miso;

    ppla_spi_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_cs_n   (spi_cs_n)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int tcyc     = 0;
    int n_resp[NR];

    always @(posedge clock) tcyc <= tcyc + 1;

    always @(negedge clock) begin
        for (int i = 0; i < NR; i++) if (resp_valid[i]) n_resp[i] <= n_resp[i] + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tcyc, act, exp);
        end
    endtask

    // Slave: mode 0, presents MSB at CS fall, shifts on SCK fall, captures MOSI on SCK rise.
    logic          loopback    = 1'b1;
    logic [DW-1:0] slave_word  = '0;
    logic [DW-1:0] slave_rx    = '0;
    int            sl_idx      = 0;
    int            n_rise      = 0;
    wire           cs_idle     = &spi_cs_n;

    always @(negedge spi_sck or posedge cs_idle) begin
        if (cs_idle) sl_idx <= 0;
        else         sl_idx <= sl_idx + 1;
    end

    always @(posedge spi_sck or negedge cs_idle) begin
        if (!spi_sck) begin
            slave_rx <= '0;
            n_rise   <= 0;
        end else begin
            slave_rx <= {slave_rx[DW-2:0], spi_mosi};
            n_rise   <= n_rise + 1;
        end
    end

    always_comb begin
        spi_miso = 1'b0;
        if (loopback)        spi_miso = spi_mosi;
        else if (sl_idx < DW) spi_miso = slave_word[DW-1-sl_idx];
    end

    // Behavioural model: arbitration by rule, bus waveform from the offset since accept.
    int            m_busy = 0, m_start = 0, m_g = 0, m_ptr = 0, m_gid = 0;
    logic [DW-1:0] m_wd = '0, m_rd = '0;

    function automatic int pick(input logic [NR-1:0] v, input int ptr, output int nptr);
        nptr = ptr;
`ifdef PPLA_SPI_ARBITER_PRIO0_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int i = 0; i < NR; i++) begin
            if (v[(ptr + i) % NR]) begin
                nptr = (ptr + i + 1) % NR;
                return (ptr + i) % NR;
            end
        end
        return 0;
    endfunction

    always @(negedge clock) begin : model
        logic [NR-1:0] e_ready, e_resp, e_cs;
        logic          e_busy, e_sck, e_mosi, chk_mosi, chk_rd;
        int            k, g, np, j;
        e_ready = '0; e_resp = '0; e_cs = '1; e_busy = 1'b0; e_sck = 1'b0; e_mosi = 1'b0;
        chk_mosi = 1'b0; chk_rd = 1'b0; k = 0; g = 0; np = m_ptr; j = 0;
        if (m_busy != 0) begin
            k      = tcyc - m_start;
            e_busy = 1'b1;
            if (k <= S) begin
                e_cs[m_g] = 1'b0; e_mosi = m_wd[DW-1]; chk_mosi = 1'b1;
            end else if (k <= S + SH) begin
                j = k - S - 1;
                e_cs[m_g] = 1'b0;
                e_sck     = (j % (2 * CD)) >= CD;
                e_mosi    = m_wd[DW-1-j/(2*CD)];
                chk_mosi  = 1'b1;
            end else if (k < LAT) begin
                e_cs[m_g] = 1'b0;
            end else begin
                e_resp[m_g] = 1'b1; chk_rd = 1'b1;
            end
        end else if (!reset && req_valid != '0) begin
            g = pick(req_valid, m_ptr, np);
            e_ready[g] = 1'b1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("resp_valid", resp_valid, e_resp);
        chk("spi_cs_n", spi_cs_n, e_cs);
        chk("busy", busy, e_busy);
        chk("spi_sck", spi_sck, e_sck);
        chk("grant_id", grant_id, m_gid);
        if (chk_mosi) chk("spi_mosi", spi_mosi, e_mosi);
        if (chk_rd)   chk("resp_rdata", resp_rdata, m_rd);
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_gid = 0;
        end else if (m_busy != 0 && k == LAT) begin
            m_busy = 0;
        end else if (m_busy == 0 && e_ready != '0) begin
            m_busy = 1; m_start = tcyc; m_g = g; m_gid = g; m_ptr = np;
            m_wd = req_wdata[g*DW +: DW];
            m_rd = loopback ? m_wd : slave_word;
        end
    end

    task automatic wait_ready(output int g, output int at);
        int n;
        n = 0; g = -1; at = 0;
        do begin
            @(negedge clock);
            n++;
        end while (n < 2000 && req_ready == '0);
        chk("accept_seen", |req_ready, 1);
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        at = tcyc;
    endtask

    task automatic wait_resp(input int idx, output int at, output logic [DW-1:0] rd);
        int n, i;
        n = 0; i = (idx < 0) ? 0 : idx;
        do begin
            @(negedge clock);
            n++;
        end while (n < 2000 && !resp_valid[i]);
        chk("resp_seen", resp_valid[i], 1);
        at = tcyc;
        rd = resp_rdata;
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            g, acc, rsp, base;
        int            gs[8], accs[8], rsps[8], exp_g[8], ntx;
        logic [DW-1:0] rd;

        next_cycle(3);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cs_n", spi_cs_n, 4'hF);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_grant_id", grant_id, 0);

        // Single transaction with MISO looped back from MOSI.
        loopback = 1'b1;
        req_wdata[1*DW +: DW] = 32'hA5A5_0F0F;
        req_valid = 4'b0010;
        wait_ready(g, acc);
        chk("t1_grant", g, 1);
        next_cycle(1);
        req_valid = '0;
        next_cycle(20);
        @(negedge clock);
        chk("t1_cs_n", spi_cs_n, 4'b1101);
        wait_resp(1, rsp, rd);
        chk("t1_latency", rsp - acc, 261);
        chk("t1_rdata", rd, 32'hA5A5_0F0F);
        chk("t1_sck_rises", n_rise, 32);

        // Slave returns a fixed word; the slave's captured MOSI must equal wdata.
        loopback   = 1'b0;
        slave_word = 32'h1234_5678;
        req_wdata[0 +: DW] = 32'hC35A_96E1;
        next_cycle(1);
        req_valid = 4'b0001;
        wait_ready(g, acc);
        chk("t2_grant", g, 0);
        next_cycle(1);
        req_valid = '0;
        wait_resp(0, rsp, rd);
        chk("t2_rdata", rd, 32'h1234_5678);
        chk("t2_slave_mosi", slave_rx, 32'hC35A_96E1);

        // Fairness from a freshly reset pointer.
        next_cycle(1);
        reset = 1'b1;
        next_cycle(1);
        reset = 1'b0;
        loopback  = 1'b1;
        req_wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_valid = 4'b1111;
`ifdef PPLA_SPI_ARBITER_PRIO0_EN
        ntx = 7;
        exp_g = '{0, 0, 0, 1, 2, 3, 1, 0};
`else
        ntx = 5;
        exp_g = '{0, 1, 2, 3, 0, 0, 0, 0};
`endif
        for (int i = 0; i < ntx; i++) begin
            wait_ready(gs[i], accs[i]);
`ifdef PPLA_SPI_ARBITER_PRIO0_EN
            if (i == 2) begin
                next_cycle(1);
                req_valid = 4'b1110;
            end
`endif
            if (i == ntx - 1) begin
                next_cycle(1);
                req_valid = '0;
            end
            wait_resp(gs[i], rsps[i], rd);
        end
        for (int i = 0; i < ntx; i++) chk("rr_order", gs[i], exp_g[i]);
        for (int i = 0; i + 1 < ntx; i++) chk("rr_idle_gap", accs[i+1] - rsps[i], 1);

        // Withdraw after accept is ignored; a request raised and dropped while busy is lost.
        next_cycle(1);
        base = n_resp[3];
        req_valid = 4'b0100;
        wait_ready(g, acc);
        chk("t4_grant", g, 2);
        next_cycle(1);
        req_valid = '0;
        next_cycle(10);
        req_valid[3] = 1'b1;
        next_cycle(20);
        req_valid[3] = 1'b0;
        wait_resp(2, rsp, rd);
        chk("t4_rdata", rd, 32'h3333_3333);
        next_cycle(10);
        chk("t4_req3_never", n_resp[3] - base, 0);

        // Reset while shifting bit 10 drops the transaction and restarts the pointer.
        req_valid = 4'b0100;
        wait_ready(g, acc);
        chk("t5_grant", g, 2);
        base = n_resp[2];
        next_cycle(1);
        req_valid = '0;
        next_cycle(84);
        reset = 1'b1;
        next_cycle(1);
        reset = 1'b0;
        @(negedge clock);
        chk("t5_cs_n", spi_cs_n, 4'hF);
        chk("t5_sck", spi_sck, 0);
        chk("t5_busy", busy, 0);
        next_cycle(300);
        chk("t5_no_resp", n_resp[2] - base, 0);
        req_valid = 4'b1010;
        wait_ready(g, acc);
        chk("t5_ptr_restart", g, 1);
        next_cycle(1);
        req_valid = '0;
        wait_resp(1, rsp, rd);
        chk("t5_rdata", rd, 32'h2222_2222);
        chk("t5_latency", rsp - acc, 261);

        next_cycle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
